// File: rtl/km_load_ctrl_pkg.sv
// Shared parameters for the kernel-memory load controller: address width, depth, FSM encoding.
// Optional feature macro used by km_load_ctrl: KML_PASS_CNT_EN (adds the KML_PASS_CNT output).
package km_load_ctrl_pkg;

   localparam int KM_AW    = 5;
   localparam int KM_DEPTH = 1 << KM_AW;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2,
      ST_RUN   = 2'd3
   } kml_state_e;

endpackage

`ifndef KM_depth
`define KM_depth 32
`endif

// File: rtl/kml_wrap_counter.sv
// AW-bit counter with enable and synchronous clear; wraps from limit back to 0.
// Latency: count updates on the edge after en; at_lim is a combinational compare.
module kml_wrap_counter
   import km_load_ctrl_pkg::*;
#(
   parameter int AW = KM_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   input  logic [AW-1:0] limit,
   output logic [AW-1:0] cnt,
   output logic          at_lim
);

   logic [AW-1:0] cnt_q;
   logic [AW-1:0] cnt_d;

   assign cnt    = cnt_q;
   assign at_lim = (cnt_q == limit);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = at_lim ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/km_load_ctrl.sv
// Owns the kernel-memory port: loads 1-32 coefficients from a valid/ready stream, then walks read addresses.
// Outputs are combinational decodes of state/counters; define KML_PASS_CNT_EN to add the pass counter.
module km_load_ctrl
   import km_load_ctrl_pkg::*;
#(
   parameter int DW = 16,
   parameter int AW = KM_AW
) (
   input  logic          KML_CLK,
   input  logic          KML_RST,
   input  logic          KML_LOAD,
   input  logic [AW-1:0] KML_LEN,
   input  logic [DW-1:0] KML_DIN,
   input  logic          KML_DIN_VALID,
   output logic          KML_DIN_READY,
   input  logic          KML_RUN,
   input  logic          KML_ADV,
   output logic          KM_WE,
   output logic [AW-1:0] KM_ADDR,
   output logic [DW-1:0] KM_DIN,
   output logic          KML_COEF_VALID,
   output logic          KML_LAST,
   output logic          KML_LOADED
`ifdef KML_PASS_CNT_EN
   ,
   output logic [15:0]   KML_PASS_CNT
`endif
);

   kml_state_e    state_q, state_d;
   logic [AW-1:0] len_q, len_d;

   logic [AW-1:0] wcnt, rcnt;
   logic          w_at_lim, r_at_lim;
   logic          load_acc, hs, adv_acc;

   // RUN has priority over a reload request in READY
   assign load_acc = KML_LOAD & ((state_q == ST_IDLE) | ((state_q == ST_READY) & ~KML_RUN));
   assign hs       = (state_q == ST_LOAD) & KML_DIN_VALID;
   assign adv_acc  = (state_q == ST_RUN) & KML_RUN & KML_ADV;

   assign KM_DIN = KML_DIN;

   kml_wrap_counter #(.AW(AW)) u_wcnt (
      .clk    (KML_CLK),
      .rst    (KML_RST),
      .en     (hs),
      .clr    (state_q != ST_LOAD),
      .limit  (len_q),
      .cnt    (wcnt),
      .at_lim (w_at_lim)
   );

   // Cleared in the cycle RUN drops so READY always presents address 0
   kml_wrap_counter #(.AW(AW)) u_rcnt (
      .clk    (KML_CLK),
      .rst    (KML_RST),
      .en     (adv_acc),
      .clr    ((state_q != ST_RUN) | ~KML_RUN),
      .limit  (len_q),
      .cnt    (rcnt),
      .at_lim (r_at_lim)
   );

   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      KML_DIN_READY  = 1'b0;
      KM_WE          = 1'b0;
      KM_ADDR        = rcnt;
      KML_COEF_VALID = 1'b0;
      KML_LAST       = 1'b0;
      KML_LOADED     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_acc) begin
               state_d = ST_LOAD;
               len_d   = KML_LEN;
            end
         end
         ST_LOAD: begin
            KML_DIN_READY = 1'b1;
            KM_ADDR       = wcnt;
            KM_WE         = KML_DIN_VALID;
            if (hs && w_at_lim) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            KML_LOADED = 1'b1;
            if (KML_RUN) begin
               state_d = ST_RUN;
            end else if (load_acc) begin
               state_d = ST_LOAD;
               len_d   = KML_LEN;
            end
         end
         ST_RUN: begin
            KML_LOADED     = 1'b1;
            KML_COEF_VALID = 1'b1;
            KML_LAST       = r_at_lim;
            if (!KML_RUN) begin
               state_d = ST_READY;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge KML_CLK) begin
      if (KML_RST) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
      end
   end

`ifdef KML_PASS_CNT_EN
   logic [15:0] pass_cnt_q, pass_cnt_d;

   assign KML_PASS_CNT = pass_cnt_q;

   always_comb begin
      pass_cnt_d = pass_cnt_q;
      if (load_acc) begin
         pass_cnt_d = '0;
      end else if (adv_acc && r_at_lim && (pass_cnt_q != 16'hFFFF)) begin
         pass_cnt_d = pass_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge KML_CLK) begin
      if (KML_RST) begin
         pass_cnt_q <= '0;
      end else begin
         pass_cnt_q <= pass_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_km_load_ctrl.sv
// Directed bench for km_load_ctrl with a behavioural kernel memory; expected values are hand-derived.
module tb_km_load_ctrl;

   logic        clk;
   logic        KML_RST;
   logic        KML_LOAD;
   logic [4:0]  KML_LEN;
   logic [15:0] KML_DIN;
   logic        KML_DIN_VALID;
   logic        KML_DIN_READY;
   logic        KML_RUN;
   logic        KML_ADV;
   logic        KM_WE;
   logic [4:0]  KM_ADDR;
   logic [15:0] KM_DIN;
   logic        KML_COEF_VALID;
   logic        KML_LAST;
   logic        KML_LOADED;
`ifdef KML_PASS_CNT_EN
   logic [15:0] KML_PASS_CNT;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0] mem [32];

   km_load_ctrl #(.DW(16), .AW(5)) dut (
      .KML_CLK        (clk),
      .KML_RST        (KML_RST),
      .KML_LOAD       (KML_LOAD),
      .KML_LEN        (KML_LEN),
      .KML_DIN        (KML_DIN),
      .KML_DIN_VALID  (KML_DIN_VALID),
      .KML_DIN_READY  (KML_DIN_READY),
      .KML_RUN        (KML_RUN),
      .KML_ADV        (KML_ADV),
      .KM_WE          (KM_WE),
      .KM_ADDR        (KM_ADDR),
      .KM_DIN         (KM_DIN),
      .KML_COEF_VALID (KML_COEF_VALID),
      .KML_LAST       (KML_LAST),
      .KML_LOADED     (KML_LOADED)
`ifdef KML_PASS_CNT_EN
      ,
      .KML_PASS_CNT   (KML_PASS_CNT)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (KM_WE) mem[KM_ADDR] <= KM_DIN;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int i;
      int nwr;
      KML_RST = 1'b1; KML_LOAD = 1'b0; KML_LEN = '0; KML_DIN = '0;
      KML_DIN_VALID = 1'b0; KML_RUN = 1'b0; KML_ADV = 1'b0;
      tick(); tick();
      KML_RST = 1'b0;
      #1;
      chk("rst_we", KM_WE, 0);
      chk("rst_rdy", KML_DIN_READY, 0);
      chk("rst_cv", KML_COEF_VALID, 0);
      chk("rst_last", KML_LAST, 0);
      chk("rst_loaded", KML_LOADED, 0);
      chk("rst_addr", KM_ADDR, 0);

      // load 8 coefficients with continuous valid
      KML_LOAD = 1'b1; KML_LEN = 5'd7;
      tick();
      KML_LOAD = 1'b0;
      for (int k = 0; k < 8; k++) begin
         KML_DIN_VALID = 1'b1;
         KML_DIN = 16'(16'hA000 + k);
         #1;
         chk("ld_we", KM_WE, 1);
         chk("ld_addr", KM_ADDR, k);
         chk("ld_rdy", KML_DIN_READY, 1);
         chk("ld_loaded", KML_LOADED, 0);
         tick();
      end
      KML_DIN_VALID = 1'b0;
      #1;
      chk("ld_done_loaded", KML_LOADED, 1);
      chk("ld_done_we", KM_WE, 0);
      chk("ld_done_addr", KM_ADDR, 0);

      // reload with valid toggling; a KML_LOAD pulse mid-load must be ignored
      KML_LOAD = 1'b1; KML_LEN = 5'd7;
      tick();
      KML_LOAD = 1'b0;
      i = 0; nwr = 0;
      for (int c = 0; c < 40 && i < 8; c++) begin
         KML_DIN_VALID = c[0];
         KML_LOAD = (c == 2);
         if (c[0]) KML_DIN = 16'(16'hB000 + i);
         #1;
         chk("tog_we", KM_WE, c[0]);
         if (c[0]) chk("tog_addr", KM_ADDR, i);
         chk("tog_loaded", KML_LOADED, 0);
         if (KM_WE) nwr++;
         tick();
         if (c[0]) i++;
      end
      KML_LOAD = 1'b0; KML_DIN_VALID = 1'b0;
      chk("tog_hs", i, 8);
      chk("tog_nwr", nwr, 8);
      #1;
      chk("tog_loaded_end", KML_LOADED, 1);

      // run with ADV held; KML_LOAD during RUN is ignored
      KML_RUN = 1'b1; KML_ADV = 1'b1;
      #1;
      chk("rdy_cv", KML_COEF_VALID, 0);
      tick();
      for (int k = 0; k < 20; k++) begin
         KML_LOAD = (k == 5);
         #1;
         chk("run_cv", KML_COEF_VALID, 1);
         chk("run_addr", KM_ADDR, k % 8);
         chk("run_last", KML_LAST, (k % 8) == 7);
         chk("run_coef", mem[KM_ADDR], 16'hB000 + (k % 8));
         tick();
      end
      KML_LOAD = 1'b0;

      // drop RUN at rcnt=4 with ADV high
      KML_RUN = 1'b0;
      #1;
      chk("drop_addr", KM_ADDR, 4);
      tick();
      #1;
      chk("drop_cv", KML_COEF_VALID, 0);
      chk("drop_addr0", KM_ADDR, 0);
      chk("drop_loaded", KML_LOADED, 1);

      // LOAD and RUN together in READY: RUN wins
      KML_RUN = 1'b1; KML_LOAD = 1'b1; KML_ADV = 1'b0;
      #1;
      tick();
      KML_LOAD = 1'b0;
      #1;
      chk("both_cv", KML_COEF_VALID, 1);
      chk("both_addr", KM_ADDR, 0);
      chk("both_loaded", KML_LOADED, 1);
      tick();
      chk("noadv_addr", KM_ADDR, 0);
`ifdef KML_PASS_CNT_EN
      chk("pcnt_2", KML_PASS_CNT, 2);
`endif
      KML_RUN = 1'b0;
      tick();

      // one-coefficient kernel
      KML_LOAD = 1'b1; KML_LEN = 5'd0;
      #1;
      tick();
      KML_LOAD = 1'b0; KML_DIN_VALID = 1'b1; KML_DIN = 16'hC000;
      #1;
      chk("l0_we", KM_WE, 1);
      chk("l0_addr", KM_ADDR, 0);
      tick();
      KML_DIN_VALID = 1'b0;
      #1;
      chk("l0_loaded", KML_LOADED, 1);
`ifdef KML_PASS_CNT_EN
      chk("pcnt_clr", KML_PASS_CNT, 0);
`endif
      KML_RUN = 1'b1; KML_ADV = 1'b1;
      tick();
      for (int j = 0; j < 3; j++) begin
         #1;
         chk("l0_last", KML_LAST, 1);
         chk("l0_raddr", KM_ADDR, 0);
         chk("l0_coef", mem[KM_ADDR], 16'hC000);
         tick();
      end
      KML_RUN = 1'b0;
      #1;
      tick();
      #1;
      chk("l0_stop_cv", KML_COEF_VALID, 0);
`ifdef KML_PASS_CNT_EN
      chk("pcnt_3", KML_PASS_CNT, 3);
`endif
      KML_ADV = 1'b0;

      // reset on the 3rd handshake of a load
      KML_LOAD = 1'b1; KML_LEN = 5'd7;
      #1;
      tick();
      KML_LOAD = 1'b0; KML_DIN_VALID = 1'b1;
      for (int h = 0; h < 2; h++) begin
         KML_DIN = 16'(16'hD000 + h);
         #1;
         chk("rl_addr", KM_ADDR, h);
         tick();
      end
      KML_DIN = 16'hD002;
      KML_RST = 1'b1;
      #1;
      tick();
      KML_RST = 1'b0;
      #1;
      chk("rl_we", KM_WE, 0);
      chk("rl_rdy", KML_DIN_READY, 0);
      chk("rl_cv", KML_COEF_VALID, 0);
      chk("rl_last", KML_LAST, 0);
      chk("rl_loaded", KML_LOADED, 0);
      chk("rl_addr0", KM_ADDR, 0);
`ifdef KML_PASS_CNT_EN
      chk("rl_pcnt", KML_PASS_CNT, 0);
`endif
      KML_DIN_VALID = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
